// File: rtl/serial_word_packer_if.sv
// Byte-stream input and AHB-Lite write-master signals of the serial word packer.
// master: the packer side; slave: the stream source plus the Switch/memory side.
interface serial_word_packer_if;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic        HREADY;
  logic [1:0]  o_HTRANS;
  logic [31:0] mem_WR_addr;
  logic        mem_write_flag;
  logic [31:0] HWDATA_toMem;

  modport master (
    input  i_byte, i_byte_valid, HREADY,
    output o_HTRANS, mem_WR_addr, mem_write_flag, HWDATA_toMem
  );

  modport slave (
    output i_byte, i_byte_valid, HREADY,
    input  o_HTRANS, mem_WR_addr, mem_write_flag, HWDATA_toMem
  );
endinterface

// File: rtl/serial_word_packer.sv
// Packs a serialized byte stream into 32-bit little-endian words and writes them out as an
// AHB-Lite master through a small word FIFO. Define PACKER_BURST_EN for overlapped SEQ beats.
module serial_word_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 i_start,
  input  logic [31:0]          i_dest_addr,
  input  logic [LEN_W-1:0]     i_byte_len,
  serial_word_packer_if.master bus,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_overflow,
  output logic [LEN_W-1:0]     o_word_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
`ifdef PACKER_BURST_EN
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] total_q, total_d;
  logic [LEN_W-1:0] taken_q, taken_d;
  logic [1:0]       lane_q, lane_d;
  logic [31:0]      pack_q, pack_d;
  logic [31:0]      fifo_q [FIFO_DEPTH];
  logic [31:0]      fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic [LEN_W-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]       htrans_q, htrans_d;
  logic [31:0]      haddr_q, haddr_d;
  logic             hwrite_q, hwrite_d;
  logic [31:0]      hwdata_q, hwdata_d;

  logic        push, pop, drop, last_word;
  logic [31:0] word_w;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    total_d    = total_q;
    taken_d    = taken_q;
    lane_d     = lane_q;
    pack_d     = pack_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    word_cnt_d = word_cnt_q;
    htrans_d   = htrans_q;
    haddr_d    = haddr_q;
    hwrite_d   = hwrite_q;
    hwdata_d   = hwdata_q;
    push       = 1'b0;
    pop        = 1'b0;
    drop       = 1'b0;
    last_word  = (word_cnt_q + LEN_W'(1)) == total_q;
    word_w     = pack_q | (32'(bus.i_byte) << {lane_q, 3'b000});

    if (i_start && !busy_q && state_q == S_IDLE) begin
      addr_d     = i_dest_addr & 32'hFFFF_FFFC;
      len_d      = i_byte_len;
      total_d    = LEN_W'(i_byte_len >> 2) + LEN_W'(|i_byte_len[1:0]);
      taken_d    = '0;
      lane_d     = 2'd0;
      pack_d     = '0;
      word_cnt_d = '0;
      ovf_d      = 1'b0;
      if (i_byte_len == '0) done_d = 1'b1;
      else                  busy_d = 1'b1;
    end

    if (busy_q && bus.i_byte_valid && taken_q < len_q) begin
      taken_d = taken_q + LEN_W'(1);
      if (lane_q == 2'd3 || taken_q == len_q - LEN_W'(1)) begin
        push   = 1'b1;
        lane_d = 2'd0;
        pack_d = '0;
      end else begin
        lane_d = lane_q + 2'd1;
        pack_d = word_w;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d  = S_ADDR;
          htrans_d = HTRANS_NONSEQ;
          haddr_d  = addr_q;
        end
      end
      S_ADDR: begin
        if (bus.HREADY) begin
          state_d  = S_DATA;
          hwrite_d = 1'b1;
          hwdata_d = fifo_q[rd_ptr_q];
          htrans_d = HTRANS_IDLE;
`ifdef PACKER_BURST_EN
          if (count_q >= CNT_W'(2)) begin
            htrans_d = HTRANS_SEQ;
            haddr_d  = addr_q + 32'd4;
          end
`endif
        end
      end
      S_DATA: begin
        if (bus.HREADY) begin
          pop      = 1'b1;
          addr_d   = addr_q + 32'd4;
          hwrite_d = 1'b0;
          htrans_d = HTRANS_IDLE;
          if (last_word) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
`ifdef PACKER_BURST_EN
            // A SEQ address phase completed alongside this data phase: its data follows now.
            if (htrans_q == HTRANS_SEQ) begin
              hwrite_d = 1'b1;
              hwdata_d = fifo_q[PTR_W'(rd_ptr_q + PTR_W'(1))];
              if (count_q >= CNT_W'(3)) begin
                htrans_d = HTRANS_SEQ;
                haddr_d  = addr_q + 32'd8;
              end
            end else if (count_q >= CNT_W'(2)) begin
              state_d  = S_ADDR;
              htrans_d = HTRANS_NONSEQ;
              haddr_d  = addr_q + 32'd4;
            end else begin
              state_d = S_IDLE;
            end
`else
            state_d = S_GAP;
`endif
          end
        end
      end
      S_GAP: begin
        if (count_q != '0) begin
          state_d  = S_ADDR;
          htrans_d = HTRANS_NONSEQ;
          haddr_d  = addr_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A full FIFO loses the new word unless the head leaves on the same edge.
    drop = push && (count_q == CNT_W'(FIFO_DEPTH)) && !pop;
    if (push && !drop) begin
      fifo_d[wr_ptr_q] = word_w;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (drop) ovf_d = 1'b1;
    count_d    = count_q + CNT_W'(push && !drop) - CNT_W'(pop);
    word_cnt_d = word_cnt_d + LEN_W'(pop) + LEN_W'(drop);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      total_q    <= '0;
      taken_q    <= '0;
      lane_q     <= '0;
      pack_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      word_cnt_q <= '0;
      htrans_q   <= HTRANS_IDLE;
      haddr_q    <= '0;
      hwrite_q   <= 1'b0;
      hwdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      total_q    <= total_d;
      taken_q    <= taken_d;
      lane_q     <= lane_d;
      pack_q     <= pack_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      word_cnt_q <= word_cnt_d;
      htrans_q   <= htrans_d;
      haddr_q    <= haddr_d;
      hwrite_q   <= hwrite_d;
      hwdata_q   <= hwdata_d;
    end
  end

  assign bus.o_HTRANS       = htrans_q;
  assign bus.mem_WR_addr    = haddr_q;
  assign bus.mem_write_flag = hwrite_q;
  assign bus.HWDATA_toMem   = hwdata_q;
  assign o_busy             = busy_q;
  assign o_done             = done_q;
  assign o_overflow         = ovf_q;
  assign o_word_cnt         = word_cnt_q;

endmodule

// File: tb/tb_serial_word_packer.sv
// Scoreboard bench for serial_word_packer: stimulus queues expected (addr, data) writes,
// a negedge monitor matches every completed AHB write against them.
module tb_serial_word_packer;
  localparam int DEPTH = 4;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        i_start;
  logic [31:0] i_dest_addr;
  logic [15:0] i_byte_len;
  logic        o_busy, o_done, o_overflow;
  logic [15:0] o_word_cnt;

  serial_word_packer_if bus_if ();

  serial_word_packer #(.FIFO_DEPTH(DEPTH), .LEN_W(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .i_start(i_start), .i_dest_addr(i_dest_addr),
    .i_byte_len(i_byte_len), .bus(bus_if), .o_busy(o_busy), .o_done(o_done),
    .o_overflow(o_overflow), .o_word_cnt(o_word_cnt)
  );

  always #5 HCLK = ~HCLK;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t         exp_q[$];
  logic [31:0] pend_addr[$];
  logic [7:0]  cur_bytes[$];

  int checks = 0, errors = 0;
  int done_cnt = 0, done_before = 0, writes_seen = 0, words_pushed = 0;
  int cur_len = 0, cur_nw = 0, hr_mode = 0;
  logic [15:0] last_done_wcnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // HREADY pattern: 0 always high, 1 random, 2 toggling, 3 held low
  initial begin
    bus_if.HREADY = 1'b1;
    forever begin
      @(posedge HCLK);
      #1;
      case (hr_mode)
        0: bus_if.HREADY = 1'b1;
        1: bus_if.HREADY = 1'($urandom_range(0, 1));
        2: bus_if.HREADY = ~bus_if.HREADY;
        default: bus_if.HREADY = 1'b0;
      endcase
    end
  end

  task automatic set_hr(input int m);
    @(negedge HCLK);
    hr_mode = m;
    tick();
  endtask

  logic        prev_dstall = 0, prev_astall = 0;
  logic [31:0] prev_data, prev_addr;
  logic [1:0]  prev_trans;

  always @(negedge HCLK) begin
    if (HRESET) begin
      pend_addr.delete();
      prev_dstall = 0;
      prev_astall = 0;
    end else begin
      if (prev_dstall) begin
        chk("hwdata_hold", bus_if.HWDATA_toMem, prev_data);
        chk("wflag_hold", 32'(bus_if.mem_write_flag), 1);
      end
      if (prev_astall) begin
        chk("haddr_hold", bus_if.mem_WR_addr, prev_addr);
        chk("htrans_hold", 32'(bus_if.o_HTRANS), 32'(prev_trans));
      end
`ifndef PACKER_BURST_EN
      if (bus_if.o_HTRANS != 2'b00) chk("no_seq", 32'(bus_if.o_HTRANS == 2'b11), 0);
`endif
      if (o_done) begin
        done_cnt++;
        last_done_wcnt = o_word_cnt;
      end
      if (bus_if.mem_write_flag && bus_if.HREADY) begin
        writes_seen++;
        chk("write_expected", 32'(exp_q.size() != 0 && pend_addr.size() != 0), 1);
        if (exp_q.size() != 0 && pend_addr.size() != 0) begin
          wr_t e;
          logic [31:0] a;
          e = exp_q.pop_front();
          a = pend_addr.pop_front();
          chk("write_addr", a, e.a);
          chk("write_data", bus_if.HWDATA_toMem, e.d);
        end
      end
      if (bus_if.o_HTRANS != 2'b00 && bus_if.HREADY) pend_addr.push_back(bus_if.mem_WR_addr);
      prev_dstall = bus_if.mem_write_flag && !bus_if.HREADY;
      prev_data   = bus_if.HWDATA_toMem;
      prev_astall = (bus_if.o_HTRANS != 2'b00) && !bus_if.HREADY;
      prev_addr   = bus_if.mem_WR_addr;
      prev_trans  = bus_if.o_HTRANS;
    end
  end

  // Reference: word j is bytes 4j..4j+3 little-endian, zero-padded, at dest&~3 + 4j.
  task automatic start_job(input logic [31:0] dest, input int len, input int keep);
    cur_len = len;
    cur_nw  = (len + 3) / 4;
    for (int j = 0; j < cur_nw; j++) begin
      wr_t e;
      e.d = 32'h0;
      for (int b = 0; b < 4; b++)
        if (4 * j + b < len) e.d = e.d | (32'(cur_bytes[4 * j + b]) << (8 * b));
      e.a = (dest & 32'hFFFF_FFFC) + 32'(4 * j);
      if (j < keep) exp_q.push_back(e);
    end
    done_before = done_cnt;
    i_start     = 1'b1;
    i_dest_addr = dest;
    i_byte_len  = 16'(len);
    tick();
    i_start = 1'b0;
  endtask

  task automatic send_bytes(input int gap_max, input bit flowctl, input int n);
    for (int k = 0; k < n; k++) begin
      bit completes;
      int t;
      completes = (k % 4 == 3) || (k == cur_len - 1);
      repeat ($urandom_range(0, gap_max)) begin
        bus_if.i_byte = 8'($urandom);
        tick();
      end
      if (flowctl && completes) begin
        t = 0;
        while (words_pushed - writes_seen >= DEPTH && t < 1000) begin tick(); t++; end
        if (t >= 1000) chk("flow_wait_timeout", 1, 0);
      end
      bus_if.i_byte       = cur_bytes[k];
      bus_if.i_byte_valid = 1'b1;
      if (k == 1) begin
        i_start     = 1'b1;
        i_dest_addr = $urandom;
        i_byte_len  = 16'd3;
      end
      if (completes) words_pushed++;
      tick();
      i_start             = 1'b0;
      bus_if.i_byte_valid = 1'b0;
    end
    if (n == cur_len) begin
      bus_if.i_byte       = 8'hEE;
      bus_if.i_byte_valid = 1'b1;
      repeat (2) tick();
      bus_if.i_byte_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input bit exp_ovf);
    int t = 0;
    while (done_cnt == done_before && t < 3000) begin tick(); t++; end
    if (t >= 3000) chk("done_timeout", 1, 0);
    repeat (3) tick();
    chk("done_pulses", 32'(done_cnt - done_before), 1);
    chk("done_word_cnt", 32'(last_done_wcnt), 32'(cur_nw));
    chk("word_cnt_hold", 32'(o_word_cnt), 32'(cur_nw));
    chk("busy_after_done", 32'(o_busy), 0);
    chk("overflow", 32'(o_overflow), 32'(exp_ovf));
    chk("writes_left", 32'(exp_q.size()), 0);
    chk("htrans_idle_after", 32'(bus_if.o_HTRANS), 0);
    words_pushed = writes_seen;
  endtask

  task automatic fill_random(input int len);
    cur_bytes.delete();
    for (int i = 0; i < len; i++) cur_bytes.push_back(8'($urandom));
  endtask

  task automatic run_job(input logic [31:0] dest, input int len, input int gap);
    start_job(dest, len, (len + 3) / 4);
    send_bytes(gap, 1'b1, len);
    wait_done(1'b0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_htrans"}, 32'(bus_if.o_HTRANS), 0);
    chk({tag, "_haddr"}, bus_if.mem_WR_addr, 0);
    chk({tag, "_wflag"}, 32'(bus_if.mem_write_flag), 0);
    chk({tag, "_hwdata"}, bus_if.HWDATA_toMem, 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_ovf"}, 32'(o_overflow), 0);
    chk({tag, "_wcnt"}, 32'(o_word_cnt), 0);
  endtask

  initial begin
    HRESET = 1'b1;
    i_start = 1'b0;
    i_dest_addr = '0;
    i_byte_len = '0;
    bus_if.i_byte = '0;
    bus_if.i_byte_valid = 1'b0;
    repeat (3) tick();
    chk_outputs_zero("reset");
    HRESET = 1'b0;
    tick();
    chk_outputs_zero("post_reset");

    // T1 / T2: fixed patterns, full-word and zero-padded tail
    set_hr(0);
    cur_bytes.delete();
    for (int i = 1; i <= 8; i++) cur_bytes.push_back(8'(i));
    run_job(32'h0000_1000, 8, 0);
    cur_bytes.delete();
    for (int i = 0; i < 6; i++) cur_bytes.push_back(8'(8'hAA + i));
    run_job(32'h0000_1103, 6, 1);

    // T4: toggling grant, address wrap past 0xFFFFFFFC
    set_hr(2);
    fill_random(8);
    run_job(32'hFFFF_FFFC, 8, 0);

    // T3: grant withheld while a long job streams in
    set_hr(3);
    fill_random(24);
    start_job(32'h0000_4000, 24, DEPTH);
    send_bytes(0, 1'b0, 24);
    repeat (5) tick();
    set_hr(0);
    wait_done(1'b1);
    set_hr(3);
    fill_random(16);
    start_job(32'h0000_4100, 16, 4);
    send_bytes(0, 1'b0, 16);
    repeat (40) tick();
    set_hr(0);
    wait_done(1'b0);

    // T5: zero-length job
    cur_bytes.delete();
    start_job(32'h0000_5000, 0, 0);
    @(negedge HCLK);
    chk("zero_done", 32'(o_done), 1);
    chk("zero_busy", 32'(o_busy), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      chk("zero_done_low", 32'(o_done), 0);
      chk("zero_htrans", 32'(bus_if.o_HTRANS), 0);
    end
    chk("zero_wcnt", 32'(o_word_cnt), 0);
    tick();
    chk("zero_pulses", 32'(done_cnt - done_before), 1);

    // T5: reset in the middle of a pending write
    set_hr(3);
    fill_random(8);
    start_job(32'h0000_6000, 8, 0);
    send_bytes(0, 1'b0, 4);
    repeat (3) tick();
    chk("midrst_pending", 32'(bus_if.o_HTRANS), 32'(2'b10));
    HRESET = 1'b1;
    #1;
    chk_outputs_zero("midrst");
    exp_q.delete();
    hr_mode = 0;
    repeat (2) tick();
    HRESET = 1'b0;
    words_pushed = 0;
    writes_seen = 0;
    tick();
    fill_random(7);
    run_job(32'h0000_7000, 7, 0);

    // Randomized jobs under random grant
    set_hr(1);
    for (int n = 0; n < 12; n++) begin
      int len;
      len = $urandom_range(1, 37);
      fill_random(len);
      run_job($urandom, len, $urandom_range(0, 3));
    end

`ifdef PACKER_BURST_EN
    // T6: prefilled FIFO released in one burst
    begin
      logic [1:0] seq[5];
      int w0;
      seq = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b00};
      set_hr(3);
      fill_random(16);
      start_job(32'h0000_8000, 16, 4);
      send_bytes(0, 1'b0, 16);
      repeat (3) tick();
      @(negedge HCLK);
      hr_mode = 0;
      w0 = writes_seen;
      for (int i = 0; i < 5; i++) begin
        @(negedge HCLK);
        chk("burst_htrans", 32'(bus_if.o_HTRANS), 32'(seq[i]));
      end
      chk("burst_writes", 32'(writes_seen - w0), 4);
      tick();
      wait_done(1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
